kypd_scanner: RTL and testbench
===============================

Name: kypd_scanner

Overview:
- Upstream stage of the PicoBlaze menu controller.
- Scans the 4x4 keypad by driving one column low at a time and reading the rows.
- Debounces whole-keypad snapshots and turns each new stable key press into a latched 4-bit key code with a ready/ack handshake, which the controller exposes on a PicoBlaze input port.
- Replaces the per-pin debouncer/clock_divider path for keypad input.

Parameters:
- SETTLE_CYCLES, 1000, clocks a column is held low before rows are sampled (10 us at 100 MHz); legal minimum 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a new stable state; legal minimum 1.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- kypd_row  in  4  keypad rows, active-low, pulled up externally, asynchronous.
- kypd_col  out  4  keypad column drive, active-low, at most one bit low at any time.
- key_code  out  4  latched code of the last accepted press.
- key_ready  out  1  high while key_code holds an unacknowledged press.
- key_ack  in  1  one-cycle pulse from the controller (PicoBlaze read strobe of the key port); clears key_ready.
- key_down  out  1  debounced level: a single key is currently held.
- key_overrun  out  1  sticky: a press was dropped while key_ready was high.

Behaviour:
- Reset values (synchronous, active-high): kypd_col=4'b1111, key_code=0, key_ready=0, key_down=0, key_overrun=0. Column index=0, settle and debounce counters=0, stable state=NONE, candidate=NONE.
- Row synchroniser: kypd_row passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- FSM state DRIVE:
  - kypd_col drives the current column low (col0 -> 4'b1110, col1 -> 4'b1101, ...) for SETTLE_CYCLES cycles.
  - Then go to SAMPLE.
- FSM state SAMPLE (1 cycle):
  - Record the inverted synchronised rows into that column's 4 bits of a 16-bit snapshot.
  - Advance the column (3 wraps to 0) and return to DRIVE.
  - kypd_col switches to the next column on the cycle after SAMPLE.
- Scan period: 4*(SETTLE_CYCLES+1) clocks. The first DRIVE starts the cycle after reset deasserts.
- End of scan (the SAMPLE of col3) classifies the snapshot:
  - Zero bits set -> NONE.
  - Exactly one bit set -> KEY(code).
  - Two or more bits set -> NONE (ghost/chord rejection).
- Key map (row r, col c -> code), matching the Pmod KYPD legend:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Debounce:
  - If the scan result equals the candidate, increment the counter, saturating at DEBOUNCE_SCANS. Otherwise load candidate=result and set the counter to 1.
  - When the counter reaches DEBOUNCE_SCANS and candidate != stable state, set stable=candidate.
- Stable-state outputs:
  - key_down=1 exactly when the stable state is KEY.
  - A press event fires on a stable transition into KEY(k) from NONE or from KEY(j), j!=k.
  - Release (KEY to NONE) produces no event.
  - Holding a key produces no auto-repeat.
- Press event with key_ready=0: key_code<=k and key_ready<=1 on the same cycle as the stable update.
- Press event with key_ready=1 and no key_ack that cycle: key_code keeps the oldest value and key_overrun<=1.
- key_ack behaviour:
  - key_ack clears key_ready and key_overrun on the next edge.
  - key_ack while key_ready=0 has no effect.
  - key_ack and a press event in the same cycle: the event wins. key_code<=k, key_ready stays 1, key_overrun<=0.
- Latency: a clean press is reported at the end of the DEBOUNCE_SCANS-th full scan that sees it, no earlier than 2 cycles of synchroniser delay.
- Reset mid-scan: all state returns to reset values on the next edge. A partial snapshot is discarded, and no event is generated from it.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, scan period 20 clocks):
- Reset, no keys pressed:
  - kypd_col cycles 1110,1101,1011,0111, each low for exactly 5 clocks.
  - key_ready=0, key_down=0 for 200 clocks.
- Key r1/c2 held (row1 pulled low while col2 is low):
  - After the 2nd full scan, key_code=6, key_ready=1, key_down=1.
  - Holding for 10 more scans gives no further event.
  - Release: key_down=0 two scans later, key_ready unchanged.
- Bounce: key r3/c0 present in alternating scans for 6 scans, then steady:
  - No event during the bounce.
  - key_code=0 with key_ready=1 only after 2 consecutive steady scans.
- Chord: r0/c0 and r0/c1 held together -> no event, key_down=0. Releasing r0/c1 -> event with key_code=1.
- Overrun and handshake:
  - Press A (r0/c3) without ack, release, then press 5 (r1/c1) -> key_code=A, key_overrun=1.
  - key_ack -> key_ready=0, key_overrun=0.
  - Press D (r3/c3) timed so key_ack lands on the event cycle -> key_code=D, key_ready=1, key_overrun=0.
- Reset asserted during col2 DRIVE while a key is held for one scan -> all outputs reset, no spurious event. The event appears 2 full scans after reset is released.

Source files
------------

// File: rtl/kypd_scanner.sv
// Keypad column scanner for the PicoBlaze menu controller: drives one column low at a
// time, debounces whole 16-key snapshots and hands each new single-key press over with ready/ack.
module kypd_scanner #(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kypd_row,
    output logic [3:0] kypd_col,
    output logic [3:0] key_code,
    output logic       key_ready,
    input  logic       key_ack,
    output logic       key_down,
    output logic       key_overrun
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_TARGET  = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       pressed;
        logic [3:0] code;
    } key_state_t;

    scan_state_e state, state_next;
    logic [SW-1:0] settle_cnt, settle_cnt_next;
    logic [1:0]    col_idx, col_idx_next;
    logic [3:0]    col_drive_next;

    logic [3:0]  row_meta, row_sync;
    logic [15:0] snapshot, snap_full;
    logic        scan_sample, scan_done;

    logic [4:0]  hit_count;
    logic [1:0]  hit_row, hit_col;
    key_state_t  scan_result;

    key_state_t  candidate, cand_next;
    key_state_t  stable, stable_next;
    logic [DW-1:0] deb_cnt, deb_cnt_next;
    logic        press_event;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kypd_row;
            row_sync <= row_meta;
        end
    end

    // The idle state gives one all-high cycle after reset so column 0 gets its full settle window.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            col_idx    <= 2'd0;
            kypd_col   <= 4'b1111;
        end else begin
            state      <= state_next;
            settle_cnt <= settle_cnt_next;
            col_idx    <= col_idx_next;
            kypd_col   <= col_drive_next;
        end
    end

    always_comb begin
        state_next      = state;
        settle_cnt_next = settle_cnt;
        col_idx_next    = col_idx;
        case (state)
            ST_IDLE: begin
                state_next      = ST_DRIVE;
                settle_cnt_next = '0;
            end
            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next      = ST_SAMPLE;
                    settle_cnt_next = '0;
                end else begin
                    settle_cnt_next = settle_cnt + SW'(1);
                end
            end
            ST_SAMPLE: begin
                state_next   = ST_DRIVE;
                col_idx_next = col_idx + 2'd1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        col_drive_next = (state_next == ST_IDLE) ? 4'b1111 : ~(4'b0001 << col_idx_next);
    end

    assign scan_sample = (state == ST_SAMPLE);
    assign scan_done   = scan_sample && (col_idx == 2'd3);

    // Snapshot bit c*4+r is set when row r read low while column c was driven.
    always_comb begin
        snap_full = snapshot;
        snap_full[{col_idx, 2'b00} +: 4] = ~row_sync;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
        end else if (scan_sample) begin
            snapshot <= snap_full;
        end
    end

    always_comb begin
        hit_count = '0;
        hit_row   = '0;
        hit_col   = '0;
        for (int i = 0; i < 16; i++) begin
            if (snap_full[i]) begin
                hit_count = hit_count + 5'd1;
                hit_col   = 2'(i / 4);
                hit_row   = 2'(i % 4);
            end
        end
        scan_result = '0;
        if (hit_count == 5'd1) begin
            scan_result.pressed = 1'b1;
            scan_result.code    = key_map(hit_row, hit_col);
        end
    end

    // Multi-key snapshots classify as NONE, so chords never reach the stable state.
    always_comb begin
        cand_next    = candidate;
        deb_cnt_next = deb_cnt;
        stable_next  = stable;
        press_event  = 1'b0;
        if (scan_done) begin
            if (scan_result == candidate) begin
                if (deb_cnt != DEB_TARGET) begin
                    deb_cnt_next = deb_cnt + DW'(1);
                end
            end else begin
                cand_next    = scan_result;
                deb_cnt_next = DW'(1);
            end
            if ((deb_cnt_next == DEB_TARGET) && (cand_next != stable)) begin
                stable_next = cand_next;
                press_event = cand_next.pressed;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            candidate <= '0;
            stable    <= '0;
            deb_cnt   <= '0;
        end else begin
            candidate <= cand_next;
            stable    <= stable_next;
            deb_cnt   <= deb_cnt_next;
        end
    end

    // A press arriving together with an ack replaces the acknowledged code instead of overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_code    <= 4'h0;
            key_ready   <= 1'b0;
            key_overrun <= 1'b0;
        end else if (press_event) begin
            if (!key_ready || key_ack) begin
                key_code    <= stable_next.code;
                key_ready   <= 1'b1;
                key_overrun <= 1'b0;
            end else begin
                key_overrun <= 1'b1;
            end
        end else if (key_ack && key_ready) begin
            key_ready   <= 1'b0;
            key_overrun <= 1'b0;
        end
    end

    assign key_down = stable.pressed;

endmodule

// File: tb/tb_kypd_scanner.sv
// Randomised and directed bench for kypd_scanner; a per-scan behavioural keypad model
// predicts column drive and the press/ack handshake every cycle.
module tb_kypd_scanner;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int PERIOD = 4 * (SETTLE + 1);

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] kypd_row;
    logic [3:0] kypd_col;
    logic [3:0] key_code;
    logic       key_ready;
    logic       key_ack;
    logic       key_down;
    logic       key_overrun;

    logic [15:0] pressed;
    logic [15:0] cur_pat;
    int          cyc;
    int          n_checks;
    int          n_fail;

    logic        m_ready;
    logic        m_ovr;
    logic [3:0]  m_code;
    int          m_stable;
    int          hist[$];

    logic [3:0] key_legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                    4'h4, 4'h5, 4'h6, 4'hB,
                                    4'h7, 4'h8, 4'h9, 4'hC,
                                    4'h0, 4'hF, 4'hE, 4'hD};

    kypd_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .kypd_row   (kypd_row),
        .kypd_col   (kypd_col),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .key_ack    (key_ack),
        .key_down   (key_down),
        .key_overrun(key_overrun)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) is bench bit r*4+c and pulls row r low while column c is driven low.
    always_comb begin
        kypd_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (kypd_col[c] === 1'b0)) begin
                    kypd_row[r] = 1'b0;
                end
            end
        end
    end

    function automatic logic [15:0] key_bit(input int r, input int c);
        return 16'(16'b1 << (r * 4 + c));
    endfunction

    function automatic int classify(input logic [15:0] pat);
        if ($countones(pat) != 1) return -1;
        for (int i = 0; i < 16; i++) begin
            if (pat[i]) return int'(key_legend[i]);
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, observed, expected);
        end
    endtask

    task automatic model_edge(input logic ack, input logic rst);
        int res;
        bit press;
        bit same;
        if (rst) begin
            cyc      = 0;
            m_ready  = 1'b0;
            m_ovr    = 1'b0;
            m_code   = 4'h0;
            m_stable = -1;
            hist.delete();
            return;
        end
        cyc++;
        press = 1'b0;
        res   = -1;
        if (cyc > 1 && (cyc % PERIOD) == 1) begin
            res = classify(cur_pat);
            hist.push_back(res);
            if (hist.size() > DEB) void'(hist.pop_front());
            same = (hist.size() == DEB);
            foreach (hist[i]) if (hist[i] != res) same = 1'b0;
            if (same && res != m_stable) begin
                m_stable = res;
                press    = (res >= 0);
            end
        end
        if (press) begin
            if (!m_ready || ack) begin
                m_code  = 4'(res);
                m_ready = 1'b1;
                m_ovr   = 1'b0;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack && m_ready) begin
            m_ready = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic ack, input logic rst);
        logic [3:0] exp_col;
        key_ack = ack;
        reset   = rst;
        @(posedge clk);
        model_edge(ack, rst);
        @(negedge clk);
        key_ack = 1'b0;
        if (cyc == 0) exp_col = 4'hF;
        else          exp_col = ~(4'b0001 << (((cyc - 1) / (SETTLE + 1)) % 4));
        checkOutput("kypd_col",    16'(kypd_col),    16'(exp_col));
        checkOutput("key_ready",   16'(key_ready),   16'(m_ready));
        checkOutput("key_code",    16'(key_code),    16'(m_code));
        checkOutput("key_down",    16'(key_down),    16'(m_stable >= 0));
        checkOutput("key_overrun", 16'(key_overrun), 16'(m_ovr));
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic run_scan(input logic [15:0] pat, input int ack_at);
        cur_pat = pat;
        pressed = pat;
        for (int i = 0; i < PERIOD; i++) applyStimulus(i == ack_at, 1'b0);
    endtask

    task automatic run_partial(input logic [15:0] pat, input int n);
        cur_pat = pat;
        pressed = pat;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] pat;
        int sel;
        int hold;
        int ack_at;
        reset    = 1'b1;
        key_ack  = 1'b0;
        pressed  = '0;
        cur_pat  = '0;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        m_ready  = 1'b0;
        m_ovr    = 1'b0;
        m_code   = 4'h0;
        m_stable = -1;
        @(negedge clk);
        do_reset();

        repeat (10) run_scan('0, -1);
        checkOutput("idle_ready", 16'(key_ready), 16'd0);

        run_scan(key_bit(1, 2), -1);
        run_scan(key_bit(1, 2), -1);
        checkOutput("key6_code",  16'(key_code),  16'h6);
        checkOutput("key6_ready", 16'(key_ready), 16'd1);
        repeat (10) run_scan(key_bit(1, 2), -1);
        run_scan('0, -1);
        run_scan('0, -1);
        checkOutput("release_down",  16'(key_down),  16'd0);
        checkOutput("release_ready", 16'(key_ready), 16'd1);
        run_scan('0, 7);

        for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? key_bit(3, 0) : 16'h0, -1);
        run_scan(key_bit(3, 0), -1);
        checkOutput("bounce_quiet", 16'(key_ready), 16'd0);
        run_scan(key_bit(3, 0), -1);
        checkOutput("bounce_code", 16'(key_code), 16'h0);
        run_scan('0, -1);
        run_scan('0, 3);

        repeat (3) run_scan(key_bit(0, 0) | key_bit(0, 1), -1);
        checkOutput("chord_ready", 16'(key_ready), 16'd0);
        run_scan(key_bit(0, 0), -1);
        run_scan(key_bit(0, 0), -1);
        checkOutput("chord_code", 16'(key_code), 16'h1);
        run_scan('0, -1);
        run_scan('0, 10);

        run_scan(key_bit(0, 3), -1);
        run_scan(key_bit(0, 3), -1);
        run_scan('0, -1);
        run_scan('0, -1);
        run_scan(key_bit(1, 1), -1);
        run_scan(key_bit(1, 1), -1);
        checkOutput("overrun_code", 16'(key_code),    16'hA);
        checkOutput("overrun_flag", 16'(key_overrun), 16'd1);
        run_scan('0, -1);
        run_scan('0, 4);
        checkOutput("ack_flag", 16'(key_overrun), 16'd0);
        run_scan(key_bit(3, 3), -1);
        run_scan(key_bit(3, 3), PERIOD - 1);
        checkOutput("keyD_code", 16'(key_code), 16'hD);
        run_scan('0, -1);
        run_scan('0, -1);
        run_scan(key_bit(1, 1), -1);
        run_scan(key_bit(1, 1), -1);
        run_scan('0, -1);
        run_scan('0, -1);
        run_scan(key_bit(0, 2), -1);
        run_scan(key_bit(0, 2), PERIOD - 1);
        checkOutput("ackwin_code",  16'(key_code),    16'h3);
        checkOutput("ackwin_ready", 16'(key_ready),   16'd1);
        checkOutput("ackwin_ovr",   16'(key_overrun), 16'd0);
        run_scan('0, -1);
        run_scan('0, 2);

        run_scan(key_bit(2, 1), -1);
        run_partial(key_bit(2, 1), 12);
        do_reset();
        run_scan(key_bit(2, 1), -1);
        checkOutput("rst_noevent", 16'(key_ready), 16'd0);
        run_scan(key_bit(2, 1), -1);
        checkOutput("rst_code", 16'(key_code), 16'h8);

        for (int it = 0; it < 120; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 3)      pat = '0;
            else if (sel < 8) pat = 16'(16'b1 << $urandom_range(0, 15));
            else              pat = 16'(16'b1 << $urandom_range(0, 15)) | 16'(16'b1 << $urandom_range(0, 15));
            hold = int'($urandom_range(1, 4));
            for (int h = 0; h < hold; h++) begin
                ack_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, PERIOD - 1)) : -1;
                run_scan(pat, ack_at);
            end
            if ($urandom_range(0, 24) == 0) begin
                run_partial(pat, int'($urandom_range(1, PERIOD - 1)));
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
